// File: rtl/uc_if.sv
// uc_if: control bus between the control unit `uc` and the datapath `cd`.
//   opcode[15:0] : instruction bits [31:16] presented by the datapath
//   z, carry     : registered datapath flags
//   s_inc        : 1 = PC+1, 0 = jump address INST[9:0]
//   s_inm        : 1 = immediate as ALU operand A, 0 = RD1
//   we3, wez     : register file / flag write enables
//   push, pop    : return-stack push (PC+1) / pop (into PC)
//   op_alu[2:0]  : ALU operation, 3'b000 = pass operand A
// master = control unit side, slave = datapath side.
interface uc_if;
    logic [15:0] opcode;
    logic        z;
    logic        carry;
    logic        s_inc;
    logic        s_inm;
    logic        we3;
    logic        wez;
    logic        push;
    logic        pop;
    logic [2:0]  op_alu;

    modport master (
        input  opcode, z, carry,
        output s_inc, s_inm, we3, wez, push, pop, op_alu
    );

    modport slave (
        output opcode, z, carry,
        input  s_inc, s_inm, we3, wez, push, pop, op_alu
    );
endinterface

// File: rtl/uc.sv
// uc: multi-cycle control unit for the single-cycle datapath `cd`.
// Decodes opcode[15:12] into datapath controls, squashes the wrong-path slot after a taken
// transfer, handles reset warm-up and HALT, tracks call depth and counts retired instructions.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : uc_if.master control bus (opcode/z/carry in, controls out)
//   halted     : high while in the HALT state
//   illegal    : sticky, set by an undefined class (1100-1111)
//   stk_err    : sticky, set by return-stack overflow or underflow
//   retired    : wrapping count of executed (non-squashed) instructions
module uc #(
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    uc_if.master        bus,
    output logic        halted,
    output logic        illegal,
    output logic        stk_err,
    output logic [15:0] retired
);

    localparam int unsigned DepthW = $clog2(STACK_DEPTH + 1);
    localparam logic [DepthW-1:0] DepthMax = DepthW'(STACK_DEPTH);

    typedef enum logic [1:0] {StWarm, StExec, StFlush, StHalt} state_e;

    state_e            state_q, state_d;
    logic [DepthW-1:0] depth_q, depth_d;
    logic [15:0]       retired_q, retired_d;
    logic              illegal_q, illegal_d;
    logic              stk_err_q, stk_err_d;

    // Decoded controls as if the current opcode were executing in EXEC.
    logic       d_s_inc, d_s_inm, d_we3, d_wez, d_push, d_pop;
    logic [2:0] d_op_alu;
    logic       taken, halt_op, ill_op, call_ok, ret_ok, stk_viol, jmp_cond;
    logic [3:0] cls;

    assign cls = bus.opcode[15:12];

    always_comb begin : decode
        d_s_inc  = 1'b1;
        d_s_inm  = 1'b0;
        d_we3    = 1'b0;
        d_wez    = 1'b0;
        d_push   = 1'b0;
        d_pop    = 1'b0;
        d_op_alu = 3'b000;
        taken    = 1'b0;
        halt_op  = 1'b0;
        ill_op   = 1'b0;
        call_ok  = 1'b0;
        ret_ok   = 1'b0;
        stk_viol = 1'b0;
        jmp_cond = 1'b0;
        case (cls)
            4'h0: ;
            4'h1: begin
                d_we3    = 1'b1;
                d_wez    = 1'b1;
                d_op_alu = bus.opcode[2:0];
            end
            4'h2: begin
                d_s_inm = 1'b1;
                d_we3   = 1'b1;
            end
            4'h3: begin
                d_s_inm  = 1'b1;
                d_we3    = 1'b1;
                d_wez    = 1'b1;
                d_op_alu = bus.opcode[2:0];
            end
            4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
                case (cls)
                    4'h4:    jmp_cond = 1'b1;
                    4'h5:    jmp_cond = bus.z;
                    4'h6:    jmp_cond = ~bus.z;
                    4'h7:    jmp_cond = bus.carry;
                    default: jmp_cond = ~bus.carry;
                endcase
                if (jmp_cond) begin
                    d_s_inc = 1'b0;
                    taken   = 1'b1;
                end
            end
            4'h9: begin
                // Overflowing CALL still jumps; only the push is dropped.
                d_s_inc = 1'b0;
                taken   = 1'b1;
                if (depth_q == DepthMax) begin
                    stk_viol = 1'b1;
                end else begin
                    d_push  = 1'b1;
                    call_ok = 1'b1;
                end
            end
            4'hA: begin
                // Underflowing RET falls through to PC+1 with no flush.
                if (depth_q == '0) begin
                    stk_viol = 1'b1;
                end else begin
                    d_pop  = 1'b1;
                    ret_ok = 1'b1;
                    taken  = 1'b1;
                end
            end
            4'hB: begin
                // Jump to the HALT word's own address so the PC parks on it.
                halt_op = 1'b1;
                d_s_inc = 1'b0;
            end
            default: ill_op = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StWarm;
            depth_q   <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            stk_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            depth_q   <= depth_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            stk_err_q <= stk_err_d;
        end
    end

    // Next-state logic
    always_comb begin : next_state
        state_d   = state_q;
        depth_d   = depth_q;
        retired_d = retired_q;
        illegal_d = illegal_q;
        stk_err_d = stk_err_q;
        case (state_q)
            StWarm:  state_d = StExec;
            StExec: begin
                retired_d = retired_q + 16'd1;
                illegal_d = illegal_q | ill_op;
                stk_err_d = stk_err_q | stk_viol;
                if (call_ok) begin
                    depth_d = depth_q + 1'b1;
                end else if (ret_ok) begin
                    depth_d = depth_q - 1'b1;
                end
                if (taken) begin
                    state_d = StFlush;
                end else if (halt_op) begin
                    state_d = StHalt;
                end
            end
            StFlush: state_d = StExec;
            default: state_d = StHalt;
        endcase
    end

    // Output logic: NOP everywhere except EXEC (decoded) and HALT (hold PC).
    always_comb begin : outputs
        bus.s_inc  = 1'b1;
        bus.s_inm  = 1'b0;
        bus.we3    = 1'b0;
        bus.wez    = 1'b0;
        bus.push   = 1'b0;
        bus.pop    = 1'b0;
        bus.op_alu = 3'b000;
        if (!reset) begin
            case (state_q)
                StExec: begin
                    bus.s_inc  = d_s_inc;
                    bus.s_inm  = d_s_inm;
                    bus.we3    = d_we3;
                    bus.wez    = d_wez;
                    bus.push   = d_push;
                    bus.pop    = d_pop;
                    bus.op_alu = d_op_alu;
                end
                StHalt:  bus.s_inc = 1'b0;
                default: ;
            endcase
        end
    end

    assign halted  = (state_q == StHalt);
    assign illegal = illegal_q;
    assign stk_err = stk_err_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_uc.sv
// tb_uc: directed self-checking bench for uc. Expected control vectors are queued when each
// opcode is driven and popped when the cycle's outputs are sampled on the falling edge.
module tb_uc;

    logic        clk = 1'b0;
    logic        reset;
    logic        halted, illegal, stk_err;
    logic [15:0] retired;

    uc_if bus ();

    uc #(.STACK_DEPTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.master),
        .halted  (halted),
        .illegal (illegal),
        .stk_err (stk_err),
        .retired (retired)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] ret_m   = 16'd0;
    logic [8:0]  exp_q[$];
    string       tag_q[$];

    // {s_inc, s_inm, we3, wez, push, pop, op_alu}
    function automatic logic [8:0] mk(input logic si, input logic sm, input logic w3,
                                      input logic wz, input logic ph, input logic pp,
                                      input logic [2:0] op);
        return {si, sm, w3, wz, ph, pp, op};
    endfunction

    localparam logic [8:0] Nop = 9'b1_0000_0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check();
        logic [8:0] obs;
        logic [8:0] exp;
        string      tag;
        obs = {bus.s_inc, bus.s_inm, bus.we3, bus.wez, bus.push, bus.pop, bus.op_alu};
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        chk(tag, 32'(obs), 32'(exp));
    endtask

    // Drive one cycle, queue its expected controls, check them mid-cycle, advance.
    task automatic step(input string tag, input logic [15:0] op, input logic zz,
                        input logic cc, input logic [8:0] exp, input logic cnt);
        bus.opcode = op;
        bus.z      = zz;
        bus.carry  = cc;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        if (cnt) ret_m = ret_m + 16'd1;
        @(negedge clk);
        pop_check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        bus.opcode = 16'h0000;
        bus.z      = 1'b0;
        bus.carry  = 1'b0;
        @(posedge clk);
        #1;
        step("reset_cycle_nop", 16'h1003, 1'b0, 1'b0, Nop, 1'b0);
        reset = 1'b0;
        chk("reset_retired", 32'(retired), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        chk("reset_illegal", 32'(illegal), 32'd0);
        chk("reset_stk_err", 32'(stk_err), 32'd0);

        // Warm-up then first instruction
        step("warm_nop", 16'h1003, 1'b0, 1'b0, Nop, 1'b0);
        step("first_alu", 16'h1003, 1'b0, 1'b0, mk(1, 0, 1, 1, 0, 0, 3'b011), 1'b1);
        chk("first_retired", 32'(retired), 32'(ret_m));

        // Other data classes
        step("loadi", 16'h2005, 1'b0, 1'b0, mk(1, 1, 1, 0, 0, 0, 3'b000), 1'b1);
        step("alu_imm", 16'h3004, 1'b0, 1'b0, mk(1, 1, 1, 1, 0, 0, 3'b100), 1'b1);
        step("nop", 16'h0000, 1'b0, 1'b0, Nop, 1'b1);

        // Conditional jumps
        step("jz_taken", 16'h5000, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 3'b000), 1'b1);
        step("jz_flush", 16'h1001, 1'b1, 1'b0, Nop, 1'b0);
        chk("jz_retired", 32'(retired), 32'(ret_m));
        step("jz_not_taken", 16'h5000, 1'b0, 1'b0, Nop, 1'b1);
        step("after_jz_nt", 16'h1001, 1'b0, 1'b0, mk(1, 0, 1, 1, 0, 0, 3'b001), 1'b1);
        step("jnz_taken", 16'h6000, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 3'b000), 1'b1);
        step("jnz_flush", 16'h4000, 1'b0, 1'b0, Nop, 1'b0);
        step("jc_taken", 16'h7000, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 3'b000), 1'b1);
        step("jc_flush", 16'h9000, 1'b0, 1'b1, Nop, 1'b0);
        step("jnc_not_taken", 16'h8000, 1'b0, 1'b1, Nop, 1'b1);
        step("jmp", 16'h4000, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 3'b000), 1'b1);
        step("jmp_flush", 16'h1002, 1'b0, 1'b0, Nop, 1'b0);
        chk("jumps_retired", 32'(retired), 32'(ret_m));

        // CALL overflow; CALL words in the flush slot must not push
        for (int i = 0; i < 8; i++) begin
            step("call_push", 16'h9000, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, 0, 3'b000), 1'b1);
            step("call_flush", 16'h9000, 1'b0, 1'b0, Nop, 1'b0);
        end
        chk("stk_err_before_ovf", 32'(stk_err), 32'd0);
        step("call_ovf", 16'h9000, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 3'b000), 1'b1);
        step("call_ovf_flush", 16'h9000, 1'b0, 1'b0, Nop, 1'b0);
        chk("stk_err_after_ovf", 32'(stk_err), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step("ret_pop", 16'hA000, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 1, 3'b000), 1'b1);
            step("ret_flush", 16'hA000, 1'b0, 1'b0, Nop, 1'b0);
        end
        step("ret_udf", 16'hA000, 1'b0, 1'b0, Nop, 1'b1);
        step("after_ret_udf", 16'h1002, 1'b0, 1'b0, mk(1, 0, 1, 1, 0, 0, 3'b010), 1'b1);
        chk("stk_err_sticky", 32'(stk_err), 32'd1);
        chk("stack_retired", 32'(retired), 32'(ret_m));

        // Illegal class
        chk("illegal_before", 32'(illegal), 32'd0);
        step("illegal_op", 16'hC000, 1'b0, 1'b0, Nop, 1'b1);
        chk("illegal_set", 32'(illegal), 32'd1);
        step("after_illegal", 16'h3005, 1'b0, 1'b0, mk(1, 1, 1, 1, 0, 0, 3'b101), 1'b1);
        step("illegal_f", 16'hF007, 1'b0, 1'b0, Nop, 1'b1);
        chk("illegal_sticky", 32'(illegal), 32'd1);

        // Retired wrap
        begin
            int n;
            n = 65536 - int'(ret_m);
            for (int i = 0; i < n; i++) begin
                step("wrap_nop", 16'h0000, 1'b0, 1'b0, Nop, 1'b1);
            end
        end
        chk("retired_wrap", 32'(retired), 32'd0);

        // HALT
        step("halt_exec", 16'hB000, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 3'b000), 1'b1);
        chk("halted_set", 32'(halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            step("halt_hold", (i % 2 == 0) ? 16'hB000 : 16'h1001, 1'b1, 1'b1,
                 mk(0, 0, 0, 0, 0, 0, 3'b000), 1'b0);
        end
        chk("halt_retired_frozen", 32'(retired), 32'(ret_m));
        chk("halted_still", 32'(halted), 32'd1);

        // Reset out of HALT
        reset = 1'b1;
        step("reset_from_halt", 16'h1001, 1'b0, 1'b0, Nop, 1'b0);
        reset = 1'b0;
        ret_m = 16'd0;
        chk("halted_cleared", 32'(halted), 32'd0);
        chk("illegal_cleared", 32'(illegal), 32'd0);
        chk("stk_err_cleared", 32'(stk_err), 32'd0);
        chk("retired_cleared", 32'(retired), 32'd0);
        step("warm_again", 16'h1001, 1'b0, 1'b0, Nop, 1'b0);
        step("exec_again", 16'h1001, 1'b0, 1'b0, mk(1, 0, 1, 1, 0, 0, 3'b001), 1'b1);
        // Depth was cleared: an immediate RET underflows
        step("ret_after_reset", 16'hA000, 1'b0, 1'b0, Nop, 1'b1);
        chk("stk_err_after_reset", 32'(stk_err), 32'd1);
        chk("final_retired", 32'(retired), 32'(ret_m));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
